regfile_write_arbiter: RTL

- Shares the single register-file write port between three writers:
  - the pipeline writeback stage (WB);
  - a multi-cycle long-latency unit (LONG, e.g. mul/div);
  - a debug writer (DBG).
- Sits between the writeback cycle and the register file.
- Selects one writer per cycle, stalls WB when it loses, and registers the selected write so the register file sees it one cycle later.
- A starvation counter guarantees LONG forward progress against a continuous WB stream.

---
 rtl/regarb_pkg.sv | 17 +
 rtl/regarb_starve_ctr.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regarb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  // Which requester owns the write port in a given cycle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_WB   = 2'd1,
    REQ_LONG = 2'd2,
    REQ_DBG  = 2'd3
  } reqType_t;

  localparam logic [REG_AW-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regarb_starve_ctr.sv
// Saturating count of consecutive cycles LONG has been denied; at_limit
// tells the arbiter to let LONG override WB.
module regarb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cntReg;

  assign at_limit = (cntReg == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntReg <= '0;
    end else if (clr) begin
      cntReg <= '0;
    end else if (inc && !at_limit) begin
      cntReg <= cntReg + CW'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB, LONG and DBG.
// Define REGARB_PERF_EN to add the stall/starvation performance counters.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_stall,
  input  logic              long_valid,
  input  logic [REG_AW-1:0] long_rd,
  input  logic [XLEN-1:0]   long_data,
  output logic              long_ready,
  input  logic              dbg_valid,
  input  logic [REG_AW-1:0] dbg_rd,
  input  logic [XLEN-1:0]   dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wd
`ifdef REGARB_PERF_EN
  ,
  output logic [31:0]       perf_wb_stall_cnt,
  output logic [31:0]       perf_starve_cnt
`endif
);

  reqType_t          grantType;
  logic              atLimit;
  logic              starveOverride;
  logic [REG_AW-1:0] selRd;
  logic [XLEN-1:0]   selWd;
  logic              rfWeReg;
  logic [REG_AW-1:0] rfRdReg;
  logic [XLEN-1:0]   rfWdReg;

  assign starveOverride = long_valid && atLimit;

  always_comb begin
    grantType = REQ_NONE;
    if (starveOverride)  grantType = REQ_LONG;
    else if (wb_we)      grantType = REQ_WB;
    else if (long_valid) grantType = REQ_LONG;
    else if (dbg_valid)  grantType = REQ_DBG;
  end

  always_comb begin
    selRd = wb_rd;
    selWd = wb_data;
    case (grantType)
      REQ_LONG: begin selRd = long_rd; selWd = long_data; end
      REQ_DBG:  begin selRd = dbg_rd;  selWd = dbg_data;  end
      default:  ;
    endcase
  end

  // Handshake outputs are forced low while reset is held.
  assign wb_stall   = rst && wb_we && (grantType != REQ_WB);
  assign long_ready = rst && (grantType == REQ_LONG);
  assign dbg_ready  = rst && (grantType == REQ_DBG);

  regarb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarve (
    .clk     (clk),
    .rst     (rst),
    .clr     (!long_valid || (grantType == REQ_LONG)),
    .inc     (long_valid && (grantType != REQ_LONG)),
    .at_limit(atLimit)
  );

  // An x0 write is accepted from the requester but never reaches the file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rfWeReg <= 1'b0;
      rfRdReg <= '0;
      rfWdReg <= '0;
    end else begin
      rfWeReg <= (grantType != REQ_NONE) && (selRd != X0_ADDR);
      if (grantType != REQ_NONE) begin
        rfRdReg <= selRd;
        rfWdReg <= selWd;
      end
    end
  end

  assign rf_we = rfWeReg;
  assign rf_rd = rfRdReg;
  assign rf_wd = rfWdReg;

`ifdef REGARB_PERF_EN
  logic [31:0] perfStallReg;
  logic [31:0] perfStarveReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfStallReg  <= '0;
      perfStarveReg <= '0;
    end else begin
      if (wb_stall)       perfStallReg  <= perfStallReg + 32'd1;
      if (starveOverride) perfStarveReg <= perfStarveReg + 32'd1;
    end
  end

  assign perf_wb_stall_cnt = perfStallReg;
  assign perf_starve_cnt   = perfStarveReg;
`endif

endmodule
